mem_lsu: RTL and testbench

Memory-stage load/store unit that sits between the ex2mem pipeline register and the mem2wb pipeline register. It accepts one instruction at a time from the execute stage and issues a single-beat request on the data-memory bus for loads and stores. It aligns and sign- or zero-extends load data, then presents a one-cycle `lsu_inst_valid_o` result that drives the mem2wb flow enable. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_lsu.sv | 152 +++++++++++++++
 tb/tb_mem_lsu.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: issues single-beat bus requests,
// aligns/extends load data and strobes one result per instruction.
module mem_lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic        lsu_valid_i,
   output logic        lsu_ready_o,
   input  logic        lsu_load_i,
   input  logic        lsu_store_i,
   input  logic [1:0]  lsu_size_i,
   input  logic        lsu_unsigned_i,
   input  logic [63:0] lsu_addr_i,
   input  logic [63:0] lsu_wdata_i,
   input  logic [4:0]  lsu_rd_index_i,
   input  logic        lsu_rd_en_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [63:0] mem_addr_o,
   output logic [63:0] mem_wdata_o,
   output logic [7:0]  mem_wstrb_o,
   input  logic        mem_ack_i,
   input  logic [63:0] mem_rdata_i,
   output logic        lsu_inst_valid_o,
   output logic [4:0]  lsu_rd_index_o,
   output logic        lsu_rd_en_o,
   output logic [63:0] lsu_rd_data_o,
   output logic        lsu_misalign_o
);

   typedef enum logic {IDLE, REQ} state_t;

   state_t      state;
   logic        is_mem;
   logic        misalign;
   logic [2:0]  align_mask;
   logic [7:0]  strb_base;
   logic [5:0]  wsh;
   logic [63:0] ld_shift;
   logic [63:0] ld_data;

   logic        load_q;
   logic        uns_q;
   logic        rd_en_q;
   logic [1:0]  size_q;
   logic [2:0]  off_q;
   logic [4:0]  rd_index_q;

   assign is_mem      = lsu_load_i | lsu_store_i;
   assign lsu_ready_o = (state == IDLE);
   assign mem_req_o   = (state == REQ);

   always_comb begin
      align_mask = 3'b000;
      strb_base  = 8'h01;
      unique case (lsu_size_i)
         2'd0: begin align_mask = 3'b000; strb_base = 8'h01; end
         2'd1: begin align_mask = 3'b001; strb_base = 8'h03; end
         2'd2: begin align_mask = 3'b011; strb_base = 8'h0F; end
         2'd3: begin align_mask = 3'b111; strb_base = 8'hFF; end
      endcase
   end

   assign misalign = |(lsu_addr_i[2:0] & align_mask);
   assign wsh      = {lsu_addr_i[2:0], 3'b000};
   assign ld_shift = mem_rdata_i >> {off_q, 3'b000};

   always_comb begin
      ld_data = ld_shift;
      unique case (size_q)
         2'd0: ld_data = uns_q ? {56'b0, ld_shift[7:0]}
                               : {{56{ld_shift[7]}}, ld_shift[7:0]};
         2'd1: ld_data = uns_q ? {48'b0, ld_shift[15:0]}
                               : {{48{ld_shift[15]}}, ld_shift[15:0]};
         2'd2: ld_data = uns_q ? {32'b0, ld_shift[31:0]}
                               : {{32{ld_shift[31]}}, ld_shift[31:0]};
         2'd3: ld_data = ld_shift;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         load_q           <= 1'b0;
         uns_q            <= 1'b0;
         rd_en_q          <= 1'b0;
         size_q           <= 2'd0;
         off_q            <= 3'd0;
         rd_index_q       <= 5'd0;
         mem_we_o         <= 1'b0;
         mem_addr_o       <= 64'd0;
         mem_wdata_o      <= 64'd0;
         mem_wstrb_o      <= 8'd0;
         lsu_inst_valid_o <= 1'b0;
         lsu_rd_index_o   <= 5'd0;
         lsu_rd_en_o      <= 1'b0;
         lsu_rd_data_o    <= 64'd0;
         lsu_misalign_o   <= 1'b0;
      end else begin
         lsu_inst_valid_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (lsu_valid_i) begin
                  if (!is_mem) begin
                     lsu_inst_valid_o <= 1'b1;
                     lsu_rd_index_o   <= lsu_rd_index_i;
                     lsu_rd_en_o      <= lsu_rd_en_i;
                     lsu_rd_data_o    <= lsu_addr_i;
                     lsu_misalign_o   <= 1'b0;
                  end else if (misalign) begin
                     lsu_inst_valid_o <= 1'b1;
                     lsu_rd_index_o   <= lsu_rd_index_i;
                     lsu_rd_en_o      <= 1'b0;
                     lsu_rd_data_o    <= 64'd0;
                     lsu_misalign_o   <= 1'b1;
                  end else begin
                     // load wins when both op flags are set
                     state       <= REQ;
                     load_q      <= lsu_load_i;
                     uns_q       <= lsu_unsigned_i;
                     size_q      <= lsu_size_i;
                     off_q       <= lsu_addr_i[2:0];
                     rd_en_q     <= lsu_rd_en_i;
                     rd_index_q  <= lsu_rd_index_i;
                     mem_addr_o  <= {lsu_addr_i[63:3], 3'b000};
                     mem_we_o    <= ~lsu_load_i;
                     mem_wdata_o <= lsu_load_i ? 64'd0
                                               : lsu_wdata_i << wsh;
                     mem_wstrb_o <= lsu_load_i ? 8'd0
                                               : strb_base << lsu_addr_i[2:0];
                  end
               end
            end
            REQ: begin
               if (mem_ack_i) begin
                  state            <= IDLE;
                  lsu_inst_valid_o <= 1'b1;
                  lsu_rd_index_o   <= rd_index_q;
                  lsu_misalign_o   <= 1'b0;
                  if (load_q) begin
                     lsu_rd_en_o   <= rd_en_q;
                     lsu_rd_data_o <= ld_data;
                  end else begin
                     lsu_rd_en_o   <= 1'b0;
                     lsu_rd_data_o <= 64'd0;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: vector table plus reset,
// back-to-back and abandoned-request sequences.
module tb_mem_lsu;

   logic        clk;
   logic        rst;
   logic        lsu_valid_i;
   logic        lsu_ready_o;
   logic        lsu_load_i;
   logic        lsu_store_i;
   logic [1:0]  lsu_size_i;
   logic        lsu_unsigned_i;
   logic [63:0] lsu_addr_i;
   logic [63:0] lsu_wdata_i;
   logic [4:0]  lsu_rd_index_i;
   logic        lsu_rd_en_i;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [63:0] mem_addr_o;
   logic [63:0] mem_wdata_o;
   logic [7:0]  mem_wstrb_o;
   logic        mem_ack_i;
   logic [63:0] mem_rdata_i;
   logic        lsu_inst_valid_o;
   logic [4:0]  lsu_rd_index_o;
   logic        lsu_rd_en_o;
   logic [63:0] lsu_rd_data_o;
   logic        lsu_misalign_o;

   mem_lsu dut (
      .clk              (clk),
      .rst              (rst),
      .lsu_valid_i      (lsu_valid_i),
      .lsu_ready_o      (lsu_ready_o),
      .lsu_load_i       (lsu_load_i),
      .lsu_store_i      (lsu_store_i),
      .lsu_size_i       (lsu_size_i),
      .lsu_unsigned_i   (lsu_unsigned_i),
      .lsu_addr_i       (lsu_addr_i),
      .lsu_wdata_i      (lsu_wdata_i),
      .lsu_rd_index_i   (lsu_rd_index_i),
      .lsu_rd_en_i      (lsu_rd_en_i),
      .mem_req_o        (mem_req_o),
      .mem_we_o         (mem_we_o),
      .mem_addr_o       (mem_addr_o),
      .mem_wdata_o      (mem_wdata_o),
      .mem_wstrb_o      (mem_wstrb_o),
      .mem_ack_i        (mem_ack_i),
      .mem_rdata_i      (mem_rdata_i),
      .lsu_inst_valid_o (lsu_inst_valid_o),
      .lsu_rd_index_o   (lsu_rd_index_o),
      .lsu_rd_en_o      (lsu_rd_en_o),
      .lsu_rd_data_o    (lsu_rd_data_o),
      .lsu_misalign_o   (lsu_misalign_o)
   );

   typedef struct {
      logic        ld;
      logic        st;
      logic [1:0]  sz;
      logic        uns;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      logic [4:0]  idx;
      logic        rd_en;
      int          wt;
      int          e_req;
      logic        e_mis;
      logic [63:0] e_maddr;
      logic [63:0] e_wdata;
      logic [7:0]  e_strb;
      logic        e_we;
      logic        e_rd_en;
      logic [63:0] e_data;
      logic        chk_data;
   } vec_t;

   vec_t vt[16];
   int   npass;
   int   ntot;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic idle_inputs();
      lsu_valid_i    = 1'b0;
      lsu_load_i     = 1'b0;
      lsu_store_i    = 1'b0;
      lsu_size_i     = 2'd0;
      lsu_unsigned_i = 1'b0;
      lsu_addr_i     = 64'd0;
      lsu_wdata_i    = 64'd0;
      lsu_rd_index_i = 5'd0;
      lsu_rd_en_i    = 1'b0;
   endtask

   task automatic drive(input vec_t v);
      lsu_valid_i    = 1'b1;
      lsu_load_i     = v.ld;
      lsu_store_i    = v.st;
      lsu_size_i     = v.sz;
      lsu_unsigned_i = v.uns;
      lsu_addr_i     = v.addr;
      lsu_wdata_i    = v.wdata;
      lsu_rd_index_i = v.idx;
      lsu_rd_en_i    = v.rd_en;
   endtask

   task automatic run_vec(input int n, input vec_t v);
      int  req_cyc;
      bit  got;
      string t;
      t = $sformatf("v%0d", n);
      @(negedge clk);
      chk({t, " ready_in"}, 64'(lsu_ready_o), 64'd1);
      drive(v);
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      req_cyc = 0;
      got     = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         if (c != 0) @(negedge clk);
         mem_ack_i = 1'b0;
         if (lsu_inst_valid_o) got = 1;
         else if (mem_req_o) begin
            if (req_cyc == 0) begin
               chk({t, " maddr"}, mem_addr_o, v.e_maddr);
               chk({t, " we"}, 64'(mem_we_o), 64'(v.e_we));
               chk({t, " wstrb"}, 64'(mem_wstrb_o), 64'(v.e_strb));
               if (v.e_we) chk({t, " wdata"}, mem_wdata_o, v.e_wdata);
               chk({t, " ready_req"}, 64'(lsu_ready_o), 64'd0);
            end
            req_cyc++;
            if (req_cyc > v.wt) begin
               mem_ack_i   = 1'b1;
               mem_rdata_i = v.rdata;
            end
         end
      end
      mem_ack_i = 1'b0;
      chk({t, " strobe"}, 64'(got), 64'd1);
      chk({t, " req_cycles"}, 64'(req_cyc), 64'(v.e_req));
      chk({t, " req_low"}, 64'(mem_req_o), 64'd0);
      chk({t, " ready_out"}, 64'(lsu_ready_o), 64'd1);
      chk({t, " misalign"}, 64'(lsu_misalign_o), 64'(v.e_mis));
      chk({t, " rd_en"}, 64'(lsu_rd_en_o), 64'(v.e_rd_en));
      chk({t, " rd_index"}, 64'(lsu_rd_index_o), 64'(v.idx));
      if (v.chk_data) chk({t, " rd_data"}, lsu_rd_data_o, v.e_data);
      @(negedge clk);
      chk({t, " one_strobe"}, 64'(lsu_inst_valid_o), 64'd0);
   endtask

   initial begin
      int strobes;
      npass = 0;
      ntot  = 0;
      vt[0]  = '{1,0,0,0,64'h8000_0003,0,64'h0000_0000_8000_0000,5,1,3,4,0,
                 64'h8000_0000,0,8'h00,0,1,64'hFFFF_FFFF_FFFF_FF80,1};
      vt[1]  = '{0,1,2,0,64'h8000_0004,64'h1122_3344,0,6,1,0,1,0,
                 64'h8000_0000,64'h1122_3344_0000_0000,8'hF0,1,0,0,1};
      vt[2]  = '{1,0,1,0,64'h8000_0001,0,0,7,1,0,0,1,0,0,0,0,0,0,0};
      vt[3]  = '{0,0,0,0,64'h1234_5678_9ABC_DEF0,0,0,8,1,0,0,0,0,0,0,0,1,
                 64'h1234_5678_9ABC_DEF0,1};
      vt[4]  = '{1,0,2,1,64'h14,0,64'hDEAD_BEEF_0000_0000,9,1,1,2,0,
                 64'h10,0,8'h00,0,1,64'h0000_0000_DEAD_BEEF,1};
      vt[5]  = '{1,0,2,0,64'h14,0,64'hDEAD_BEEF_0000_0000,10,1,0,1,0,
                 64'h10,0,8'h00,0,1,64'hFFFF_FFFF_DEAD_BEEF,1};
      vt[6]  = '{1,0,1,0,64'h2,0,64'h0000_0000_7FFF_0000,11,1,0,1,0,
                 64'h0,0,8'h00,0,1,64'h7FFF,1};
      vt[7]  = '{1,0,3,0,64'h8,0,64'h0123_4567_89AB_CDEF,12,1,2,3,0,
                 64'h8,0,8'h00,0,1,64'h0123_4567_89AB_CDEF,1};
      vt[8]  = '{0,1,0,0,64'h7,64'hAB,0,13,1,0,1,0,
                 64'h0,64'hAB00_0000_0000_0000,8'h80,1,0,0,1};
      vt[9]  = '{0,1,3,0,64'h18,64'hCAFE_F00D_1234_5678,0,14,0,1,2,0,
                 64'h18,64'hCAFE_F00D_1234_5678,8'hFF,1,0,0,1};
      vt[10] = '{0,1,3,0,64'h4,64'h1,0,15,1,0,0,1,0,0,0,0,0,0,0};
      vt[11] = '{1,1,3,0,64'h0,64'h77,64'hFEDC_BA98_7654_3210,16,1,0,1,0,
                 64'h0,0,8'h00,0,1,64'hFEDC_BA98_7654_3210,1};
      vt[12] = '{1,0,2,0,64'h2,0,0,17,1,0,0,1,0,0,0,0,0,0,0};
      vt[13] = '{0,1,1,0,64'h6,64'h1234,0,18,1,0,1,0,
                 64'h0,64'h1234_0000_0000_0000,8'hC0,1,0,0,1};
      vt[14] = '{0,0,0,0,64'h55AA,0,0,19,0,0,0,0,0,0,0,0,0,64'h55AA,1};
      vt[15] = '{1,0,0,1,64'h1,0,64'h0000_0000_0000_F100,20,1,0,1,0,
                 64'h0,0,8'h00,0,1,64'hF1,1};

      idle_inputs();
      mem_ack_i   = 1'b0;
      mem_rdata_i = 64'd0;
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("rst ready", 64'(lsu_ready_o), 64'd1);
      chk("rst req", 64'(mem_req_o), 64'd0);
      chk("rst valid", 64'(lsu_inst_valid_o), 64'd0);
      chk("rst rd_data", lsu_rd_data_o, 64'd0);
      chk("rst maddr", mem_addr_o, 64'd0);
      chk("rst wstrb", 64'(mem_wstrb_o), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 16; i++) run_vec(i, vt[i]);

      // back-to-back: ALU op then unsigned half load
      @(negedge clk);
      lsu_valid_i    = 1'b1;
      lsu_addr_i     = 64'h55;
      lsu_rd_index_i = 5'd3;
      lsu_rd_en_i    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("b2b alu strobe", 64'(lsu_inst_valid_o), 64'd1);
      chk("b2b alu data", lsu_rd_data_o, 64'h55);
      chk("b2b ready alu", 64'(lsu_ready_o), 64'd1);
      lsu_load_i     = 1'b1;
      lsu_size_i     = 2'd1;
      lsu_unsigned_i = 1'b1;
      lsu_addr_i     = 64'h6;
      lsu_rd_index_i = 5'd4;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      chk("b2b req", 64'(mem_req_o), 64'd1);
      chk("b2b ready req", 64'(lsu_ready_o), 64'd0);
      chk("b2b no strobe", 64'(lsu_inst_valid_o), 64'd0);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 64'hBEEF_0000_0000_0000;
      @(negedge clk);
      mem_ack_i = 1'b0;
      chk("b2b ld strobe", 64'(lsu_inst_valid_o), 64'd1);
      chk("b2b ld data", lsu_rd_data_o, 64'hBEEF);
      chk("b2b ready back", 64'(lsu_ready_o), 64'd1);

      // reset while a request is outstanding
      @(negedge clk);
      lsu_valid_i = 1'b1;
      lsu_load_i  = 1'b1;
      lsu_size_i  = 2'd3;
      lsu_addr_i  = 64'h40;
      lsu_rd_en_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      chk("rreq req", 64'(mem_req_o), 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("rreq req drop", 64'(mem_req_o), 64'd0);
      chk("rreq ready", 64'(lsu_ready_o), 64'd1);
      chk("rreq maddr", mem_addr_o, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 64'h1111_2222_3333_4444;
      @(negedge clk);
      mem_ack_i = 1'b0;
      strobes = 0;
      for (int c = 0; c < 4; c++) begin
         if (lsu_inst_valid_o) strobes++;
         @(negedge clk);
      end
      chk("rreq no strobe", 64'(strobes), 64'd0);
      chk("rreq rd_data", lsu_rd_data_o, 64'd0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
